// File: rtl/proc_bus_pkg.sv
// Shared definitions for the processor data bus: widths, arbiter FSM encoding and master indices.
package proc_bus_pkg;

    localparam int DBITS_DEF = 32;
    localparam int ABITS_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the master not granted last wins.
module rr_pick2
    import proc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = M0;
        if (req[1] && (!req[0] || last == M0))
            winner = M1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the dmem/I-O slave: IDLE -> ACCESS -> RESP, one transfer per 3 cycles.
// Optional lock feature (m0_lock/m1_lock ports) is enabled by defining ARB_LOCK_EN.
module dmem_arbiter
    import proc_bus_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int ABITS = ABITS_DEF
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [ABITS-1:0] m0_addr,
    input  logic [DBITS-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_ack,
    output logic [DBITS-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [ABITS-1:0] m1_addr,
    input  logic [DBITS-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_ack,
    output logic [DBITS-1:0] m1_rdata,
`ifdef ARB_LOCK_EN
    input  logic             m0_lock,
    input  logic             m1_lock,
`endif
    output logic             s_en,
    output logic             s_we,
    output logic [ABITS-1:0] s_addr,
    output logic [DBITS-1:0] s_wdata,
    input  logic [DBITS-1:0] s_rdata
);

    state_t     state, state_nxt;
    logic       owner, last;
    logic [1:0] req_vec, arb_req;
    logic       pick_vld, pick_win, take;
    logic       busy;

    assign req_vec = {m1_req, m0_req};

`ifdef ARB_LOCK_EN
    // lock_q is the winner's lock captured at grant; it becomes the active lock at that transfer's ack.
    logic locked, lock_q;

    assign arb_req = !locked ? req_vec :
                     (owner == M1) ? {req_vec[1], 1'b0} : {1'b0, req_vec[0]};

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            locked <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            if (take)
                lock_q <= (pick_win == M1) ? m1_lock : m0_lock;
            if (state == S_RESP)
                locked <= lock_q;
            else if (state == S_IDLE && locked && !req_vec[owner])
                locked <= 1'b0;
        end
    end
`else
    assign arb_req = req_vec;
`endif

    rr_pick2 u_pick (
        .req    (arb_req),
        .last   (last),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            owner <= M0;
            last  <= M1;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner <= pick_win;
                last  <= pick_win;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    take      = 1'b1;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // All outputs decode from state/owner so a reset forces them low immediately.
    always_comb begin
        busy     = (state == S_ACCESS) || (state == S_RESP);
        m0_gnt   = busy && (owner == M0);
        m1_gnt   = busy && (owner == M1);
        m0_ack   = (state == S_RESP) && (owner == M0);
        m1_ack   = (state == S_RESP) && (owner == M1);
        m0_rdata = m0_ack ? s_rdata : '0;
        m1_rdata = m1_ack ? s_rdata : '0;
        s_en     = (state == S_ACCESS);
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        if (s_en) begin
            s_we    = (owner == M1) ? m1_we    : m0_we;
            s_addr  = (owner == M1) ? m1_addr  : m0_addr;
            s_wdata = (owner == M1) ? m1_wdata : m0_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read slave model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_lock, m1_lock;
    logic        s_en, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = 32'h0;

    int checks = 0;
    int failures = 0;
    int n_ack0 = 0;
    int n_ack1 = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
`ifdef ARB_LOCK_EN
        .m0_lock  (m0_lock),
        .m1_lock  (m1_lock),
`endif
        .s_en     (s_en),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata)
    );

    // Slave: registered read, 0x40 holds 0xCAFEF00D, every other address reads 0x0BAD0000 ^ addr.
    always @(posedge clk)
        if (s_en && !s_we)
            s_rdata <= (s_addr == 32'h40) ? 32'hCAFEF00D : (32'h0BAD0000 ^ s_addr);

    // Protocol monitor: gnt one-hot-or-zero, s_en only with a single owner and never with ack.
    always @(negedge clk) begin
        if (RESET_N) begin
            checks++;
            if (m0_gnt && m1_gnt) begin
                failures++;
                $display("FAIL gnt_onehot: m0_gnt=%b m1_gnt=%b required not both 1", m0_gnt, m1_gnt);
            end
            checks++;
            if (s_en && (m0_ack || m1_ack || !(m0_gnt ^ m1_gnt))) begin
                failures++;
                $display("FAIL s_en_phase: s_en=1 with gnt=%b%b ack=%b%b", m1_gnt, m0_gnt, m1_ack, m0_ack);
            end
            if (m0_ack) n_ack0++;
            if (m1_ack) n_ack1++;
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_N = 0;
        m0_req = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, s_en, s_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt/ack/s_en/s_we=%b required 000000",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, s_en, s_we});
        end
        checks++;
        if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: s_addr=%h s_wdata=%h required 0", s_addr, s_wdata);
        end
        checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: m0=%h m1=%h required 0", m0_rdata, m1_rdata);
        end
        m0_req = 0;
        RESET_N = 1;
        @(negedge clk);
        checks++;
        if (s_en !== 1'b0 || m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: s_en=%b m0_gnt=%b required 0", s_en, m0_gnt);
        end
    endtask

    task automatic test_single_read();
        int a0;
        a0 = n_ack0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        @(negedge clk);
        checks++;
        if ({s_en, s_we, m0_gnt, m1_gnt, m0_ack} !== 5'b10100 || s_addr !== 32'h40) begin
            failures++;
            $display("FAIL read_access: en/we/g0/g1/ack=%b addr=%h required 10100 addr=00000040",
                     {s_en, s_we, m0_gnt, m1_gnt, m0_ack}, s_addr);
        end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'hCAFEF00D || m0_gnt !== 1'b1 || s_en !== 1'b0) begin
            failures++;
            $display("FAIL read_resp: ack=%b rdata=%h gnt=%b s_en=%b required 1 cafef00d 1 0",
                     m0_ack, m0_rdata, m0_gnt, s_en);
        end
        m0_req = 0;
        @(negedge clk);
        #1;
        checks++;
        if (m0_ack !== 1'b0 || m0_gnt !== 1'b0 || n_ack0 - a0 !== 1) begin
            failures++;
            $display("FAIL read_done: ack=%b gnt=%b acks=%0d required 0 0 1", m0_ack, m0_gnt, n_ack0 - a0);
        end
    endtask

    task automatic test_single_write();
        int a1;
        a1 = n_ack1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({s_en, s_we, m1_gnt, m0_gnt} !== 4'b1110 || s_addr !== 32'h8 || s_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL write_access: en/we/g1/g0=%b addr=%h wdata=%h required 1110 8 12345678",
                     {s_en, s_we, m1_gnt, m0_gnt}, s_addr, s_wdata);
        end
        @(negedge clk);
        checks++;
        if (m1_ack !== 1'b1 || m0_gnt !== 1'b0 || m0_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_resp: m1_ack=%b m0_gnt=%b m0_ack=%b required 1 0 0", m1_ack, m0_gnt, m0_ack);
        end
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        #1;
        checks++;
        if (n_ack1 - a1 !== 1 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL write_done: acks=%0d gnt=%b required 1 0", n_ack1 - a1, m1_gnt);
        end
    endtask

    task automatic test_tie_alternate();
        int order[4];
        int when[4];
        int n;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        order = '{-1, -1, -1, -1};
        when = '{-1, -1, -1, -1};
        n = 0;
        RESET_N = 0;
        @(negedge clk);
        RESET_N = 1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                order[n] = m1_ack ? 1 : 0;
                when[n] = cyc;
                if (m1_ack) begin
                    checks++;
                    if (m1_rdata !== 32'h0BAD0010) begin
                        failures++;
                        $display("FAIL tie_m1_rdata: got %h required 0bad0010", m1_rdata);
                    end
                end
                n++;
                if (n == 4) begin m0_req = 0; m1_req = 0; end
            end
        end
        m0_req = 0; m1_req = 0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL tie_timeout: got %0d acks required 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                failures++;
                $display("FAIL tie_order[%0d]: got M%0d required M%0d", k, order[k], exp_order[k]);
            end
        end
        checks++;
        if (when[0] !== 2) begin
            failures++;
            $display("FAIL tie_latency: first ack at cycle %0d required 2", when[0]);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (when[k] - when[k-1] !== 3) begin
                failures++;
                $display("FAIL tie_spacing[%0d]: got %0d cycles required 3", k, when[k] - when[k-1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int a0, a1;
        bit got;
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h0000DEAD;
        @(negedge clk);
        checks++;
        if (s_en !== 1'b1 || s_we !== 1'b1 || m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midop_access: s_en=%b s_we=%b gnt=%b required 1 1 1", s_en, s_we, m0_gnt);
        end
        #2 RESET_N = 0;
        #1;
        checks++;
        if ({s_en, s_we, m0_gnt, m1_gnt, m0_ack, m1_ack} !== 6'b0) begin
            failures++;
            $display("FAIL midop_async: en/we/g0/g1/a0/a1=%b required 000000",
                     {s_en, s_we, m0_gnt, m1_gnt, m0_ack, m1_ack});
        end
        a0 = n_ack0; a1 = n_ack1;
        idle_inputs();
        repeat (2) @(negedge clk);
        RESET_N = 1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (n_ack0 !== a0 || n_ack1 !== a1) begin
            failures++;
            $display("FAIL midop_no_ack: acks m0=%0d m1=%0d required %0d %0d", n_ack0, n_ack1, a0, a1);
        end
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        got = 0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                got = 1;
                checks++;
                if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL midop_first_tie: ack m0=%b m1=%b required 1 0", m0_ack, m1_ack);
                end
                m0_req = 0; m1_req = 0;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL midop_timeout: no ack after reset release tie");
        end
        idle_inputs();
        @(negedge clk);
    endtask

    // Entered with last=M0, so M1 wins the first tie.
    task automatic test_lock_order();
        int order[4];
        int exp_order[4];
        int n, m1cnt;
`ifdef ARB_LOCK_EN
        exp_order = '{1, 1, 1, 0};
`else
        exp_order = '{1, 0, 1, 0};
`endif
        order = '{-1, -1, -1, -1};
        n = 0; m1cnt = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_lock = 1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                order[n] = m1_ack ? 1 : 0;
                n++;
                if (m1_ack) begin
                    m1cnt++;
                    if (m1cnt == 2) m1_lock = 0;
                    if (m1cnt == 3) m1_req = 0;
                end
                if (n == 4) begin m0_req = 0; m1_req = 0; end
            end
        end
        idle_inputs();
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL lock_timeout: got %0d acks required 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                failures++;
                $display("FAIL lock_order[%0d]: got M%0d required M%0d", k, order[k], exp_order[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        RESET_N = 0;
        test_reset();
        test_single_read();
        test_single_write();
        test_tie_alternate();
        test_reset_mid_op();
        test_lock_order();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
